ram_moc_responder: RTL and testbench

Synchronous byte-addressed data/instruction RAM that answers the control unit's memory handshake (MFA request, MOC completion). It sits on the CPU memory bus opposite the control unit: it latches a request, waits a configurable number of cycles, performs a big-endian byte, halfword or word access, and raises MOC until the request is withdrawn. This is the responder the fetch, load and store states wait on.

---
 rtl/ram_moc_responder.sv | 147 ++++++++++++++
 tb/tb_ram_moc_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ram_moc_responder.sv
// Byte-addressed big-endian RAM that answers the MFA/MOC four-phase handshake.
// Each request is latched in IDLE, waits WAIT_CYCLES edges, then performs the access and holds MOC high.
module ram_moc_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  Type,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_rw;
    logic [1:0]      r_type;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_data_out;
    logic            r_moc;
    logic [7:0]      r_mem [0:DEPTH-1];

    logic [AW-1:0]   w_a0;
    logic [AW-1:0]   w_a1;
    logic [AW-1:0]   w_a2;
    logic [AW-1:0]   w_a3;
    logic [31:0]     w_rdata;
    logic            w_access;
    logic            w_unused_addr;

    assign w_unused_addr = ^Address[31:AW];
    assign DataOut       = r_data_out;
    assign MOC           = r_moc;

    // The access fires on the last WAIT edge, only while the request is still held.
    assign w_access = (r_state == S_WAIT) && MFA && (r_cnt == {CW{1'b0}}) && !Reset;

    // Align the latched address to the access size; byte indices wrap within the array.
    always_comb begin
        w_a0 = r_addr;
        case (r_type)
            2'b00:   w_a0 = r_addr;
            2'b01:   w_a0 = r_addr & ~AW'(1);
            default: w_a0 = r_addr & ~AW'(3);
        endcase
        w_a1 = w_a0 + AW'(1);
        w_a2 = w_a0 + AW'(2);
        w_a3 = w_a0 + AW'(3);
    end

    // Assemble big-endian read data, right-justified and zero-extended.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (r_type)
            2'b00:   w_rdata = {24'h00_0000, r_mem[w_a0]};
            2'b01:   w_rdata = {16'h0000, r_mem[w_a0], r_mem[w_a1]};
            default: w_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
        endcase
    end

    // Byte-lane writes into the array; the array is deliberately outside reset.
    always_ff @(posedge Clk) begin
        if (w_access && !r_rw) begin
            case (r_type)
                2'b00: begin
                    r_mem[w_a0] <= r_wdata[7:0];
                end
                2'b01: begin
                    r_mem[w_a0] <= r_wdata[15:8];
                    r_mem[w_a1] <= r_wdata[7:0];
                end
                default: begin
                    r_mem[w_a0] <= r_wdata[31:24];
                    r_mem[w_a1] <= r_wdata[23:16];
                    r_mem[w_a2] <= r_wdata[15:8];
                    r_mem[w_a3] <= r_wdata[7:0];
                end
            endcase
        end
    end

    // Handshake FSM with registered MOC and read data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_moc      <= 1'b0;
            r_data_out <= 32'h0000_0000;
            r_rw       <= 1'b0;
            r_type     <= 2'b00;
            r_addr     <= {AW{1'b0}};
            r_wdata    <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_moc <= 1'b0;
                    if (MFA) begin
                        r_rw    <= RW;
                        r_type  <= Type;
                        r_addr  <= Address[AW-1:0];
                        r_wdata <= DataIn;
                        r_cnt   <= CW'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!MFA) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == {CW{1'b0}}) begin
                        if (r_rw) begin
                            r_data_out <= w_rdata;
                        end
                        r_moc   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (!MFA) begin
                        r_moc   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_moc   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_moc_responder.sv
// Scoreboard bench for ram_moc_responder: directed accesses push expectations,
// a negedge monitor pops and compares them whenever MOC rises.
module tb_ram_moc_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;

    logic        Clk;
    logic        Reset;
    logic        MFA;
    logic        RW;
    logic [1:0]  Type;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;

    int n_checks = 0;
    int n_pass   = 0;
    int mon_rises = 0;

    logic        q_is_read [$];
    logic [31:0] q_exp     [$];
    logic [31:0] last_read;

    ram_moc_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .RW(RW), .Type(Type),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: on every rising MOC, pop one expectation and compare DataOut.
    initial begin : monitor
        logic prev_moc;
        logic is_rd;
        logic [31:0] exp;
        prev_moc = 1'b0;
        forever begin
            @(negedge Clk);
            if (MOC === 1'b1 && prev_moc !== 1'b1) begin
                mon_rises++;
                if (q_exp.size() == 0) begin
                    check("unexpected_moc", 32'd1, 32'd0);
                end else begin
                    is_rd = q_is_read.pop_front();
                    exp   = q_exp.pop_front();
                    check(is_rd ? "read_data" : "write_dataout_held", DataOut, exp);
                end
            end
            prev_moc = MOC;
        end
    end

    task automatic do_access(input logic rw, input logic [1:0] ty, input logic [31:0] addr,
                             input logic [31:0] din, input logic [31:0] exp, input int hold);
        int  cycles;
        int  rises0;
        logic hold_ok;
        @(negedge Clk);
        RW = rw; Type = ty; Address = addr; DataIn = din; MFA = 1'b1;
        q_is_read.push_back(rw);
        if (rw) begin
            q_exp.push_back(exp);
            last_read = exp;
        end else begin
            q_exp.push_back(last_read);
        end
        rises0 = mon_rises;
        cycles = 0;
        do begin
            @(posedge Clk); #1;
            cycles++;
            if (cycles == 1) begin
                RW = ~rw; Type = ~ty; Address = ~addr; DataIn = ~din;
            end
        end while (MOC !== 1'b1 && cycles < 50);
        if (MOC !== 1'b1) check("moc_timeout", 32'd0, 32'd1);
        else check("moc_latency", 32'(cycles - 1), 32'(WAIT_CYCLES + 1));
        if (hold > 0) begin
            hold_ok = 1'b1;
            repeat (hold) begin
                @(posedge Clk); #1;
                if (MOC !== 1'b1) hold_ok = 1'b0;
            end
            check("moc_held", {31'd0, hold_ok}, 32'd1);
            check("single_access", 32'(mon_rises - rises0), 32'd1);
        end
        @(negedge Clk);
        MFA = 1'b0;
        @(posedge Clk); #1;
        check("moc_fall", {31'd0, MOC}, 32'd0);
    endtask

    initial begin : stim
        logic quiet;
        Reset = 1'b1; MFA = 1'b0; RW = 1'b0; Type = 2'b00;
        Address = 32'h0; DataIn = 32'h0; last_read = 32'h0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_moc", {31'd0, MOC}, 32'd0);
        check("reset_dataout", DataOut, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        do_access(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        do_access(1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        do_access(1'b1, 2'b00, 32'h10, 32'h0, 32'h000000DE, 0);
        do_access(1'b1, 2'b00, 32'h13, 32'h0, 32'h000000EF, 0);
        do_access(1'b1, 2'b01, 32'h12, 32'h0, 32'h0000BEEF, 0);
        do_access(1'b1, 2'b01, 32'h13, 32'h0, 32'h0000BEEF, 0);
        do_access(1'b0, 2'b00, 32'h11, 32'h000000AA, 32'h0, 0);
        do_access(1'b1, 2'b10, 32'h10, 32'h0, 32'hDEAABEEF, 0);
        do_access(1'b0, 2'b01, 32'h12, 32'h00001234, 32'h0, 0);
        do_access(1'b1, 2'b10, 32'h10, 32'h0, 32'hDEAA1234, 0);
        do_access(1'b0, 2'b10, 32'h000001FE, 32'h01020304, 32'h0, 0);
        do_access(1'b1, 2'b10, 32'hFC, 32'h0, 32'h01020304, 0);
        do_access(1'b0, 2'b00, 32'h00, 32'h0000005A, 32'h0, 0);
        do_access(1'b1, 2'b00, 32'h100, 32'h0, 32'h0000005A, 0);
        do_access(1'b1, 2'b11, 32'hFD, 32'h0, 32'h01020304, 0);

        // Aborted write: MFA dropped after one cycle in WAIT.
        do_access(1'b0, 2'b10, 32'h20, 32'h11223344, 32'h0, 0);
        @(negedge Clk);
        RW = 1'b0; Type = 2'b10; Address = 32'h20; DataIn = 32'h55555555; MFA = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        MFA = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(posedge Clk); #1;
            if (MOC !== 1'b0) quiet = 1'b0;
        end
        check("abort_no_moc", {31'd0, quiet}, 32'd1);
        do_access(1'b1, 2'b10, 32'h20, 32'h0, 32'h11223344, 0);

        do_access(1'b1, 2'b10, 32'h10, 32'h0, 32'hDEAA1234, 10);

        // Reset during the WAIT of a write.
        do_access(1'b0, 2'b10, 32'h30, 32'h87654321, 32'h0, 0);
        @(negedge Clk);
        RW = 1'b0; Type = 2'b10; Address = 32'h30; DataIn = 32'hCAFEF00D; MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("midreset_moc", {31'd0, MOC}, 32'd0);
        check("midreset_dataout", DataOut, 32'h0);
        @(negedge Clk);
        Reset = 1'b0; MFA = 1'b0;
        last_read = 32'h0;
        repeat (2) @(posedge Clk);
        do_access(1'b1, 2'b10, 32'h30, 32'h0, 32'h87654321, 0);
        do_access(1'b1, 2'b10, 32'h10, 32'h0, 32'hDEAA1234, 0);

        repeat (3) @(posedge Clk);
        #1;
        check("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
